// File: rtl/aes_ctr_iv_reg.sv
// AES CTR counter/IV register: holds the sliced counter, queues increment
// requests and runs the sparse incr/ready handshake with the incrementer.
module aes_ctr_iv_reg #(
  parameter int NumSlices  = 8,
  parameter int SliceSize  = 16,
  parameter int MaxPending = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumSlices-1:0]           iv_we_i,
  input  logic [NumSlices*SliceSize-1:0] iv_wdata_i,
  output logic                           iv_wr_err_o,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  output logic                           done_o,
  output logic [31:0]                    blk_cnt_o,
  output logic [NumSlices*SliceSize-1:0] iv_o,
  output logic [2:0]                     incr_o,
  input  logic [2:0]                     ready_i,
  output logic [NumSlices*SliceSize-1:0] ctr_o,
  input  logic [NumSlices*SliceSize-1:0] ctr_i,
  input  logic [3*NumSlices-1:0]         ctr_we_i,
  input  logic                           alert_i,
  output logic                           alert_o
);

  localparam logic [2:0] SP2V_HIGH = 3'b011;
  localparam logic [2:0] SP2V_LOW  = 3'b100;
  localparam int PW = $clog2(MaxPending + 1);
  localparam logic [PW-1:0] PMAX = PW'(MaxPending);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    BUSY  = 3'd3,
    ERROR = 3'd4
  } state_e;

  state_e state_q;
  logic [NumSlices-1:0][SliceSize-1:0] iv_q;
  logic [PW-1:0] pend_q;
  logic [1:0]    wait_cnt_q;
  logic [31:0]   blk_cnt_q;
  logic          wr_err_q;

  logic                 rdy_hi;
  logic                 rdy_bad;
  logic [NumSlices-1:0] we_hi;
  logic                 we_bad;
  logic                 in_upd;
  logic                 state_bad;
  logic                 wait_ovf;
  logic                 fatal;
  logic                 done;
  logic                 accept;
  logic                 sw_ok;

  always_comb begin
    rdy_hi  = (ready_i == SP2V_HIGH);
    rdy_bad = (ready_i != SP2V_HIGH) && (ready_i != SP2V_LOW);
    we_hi   = '0;
    we_bad  = 1'b0;
    for (int s = 0; s < NumSlices; s++) begin
      we_hi[s] = (ctr_we_i[3*s +: 3] == SP2V_HIGH);
      if ((ctr_we_i[3*s +: 3] != SP2V_HIGH) &&
          (ctr_we_i[3*s +: 3] != SP2V_LOW)) begin
        we_bad = 1'b1;
      end
    end
    in_upd    = (state_q == WAIT) || (state_q == BUSY);
    state_bad = 1'b0;
    incr_o    = SP2V_LOW;
    unique case (state_q)
      IDLE, WAIT, BUSY, ERROR: ;
      REQ:     incr_o = SP2V_HIGH;
      default: state_bad = 1'b1;
    endcase
    // Incrementer holding ready high for a third WAIT cycle is a protocol fault.
    wait_ovf = (state_q == WAIT) && rdy_hi && (wait_cnt_q == 2'd2);
    fatal    = alert_i | rdy_bad | we_bad | state_bad | wait_ovf |
               ((|we_hi) & ~in_upd);
    done        = (state_q == BUSY) && rdy_hi && !fatal;
    req_ready_o = (pend_q < PMAX) && (state_q != ERROR);
    accept      = req_valid_i && req_ready_o;
    sw_ok       = (state_q == IDLE) && (pend_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      iv_q       <= '0;
      pend_q     <= '0;
      wait_cnt_q <= '0;
      blk_cnt_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_err_q  <= (|iv_we_i) && !sw_ok;
      blk_cnt_q <= blk_cnt_q + 32'(done);
      if (accept && !done) begin
        pend_q <= pend_q + PW'(1);
      end else if (done && !accept) begin
        pend_q <= pend_q - PW'(1);
      end
      for (int s = 0; s < NumSlices; s++) begin
        if (sw_ok && iv_we_i[s]) begin
          iv_q[s] <= iv_wdata_i[s*SliceSize +: SliceSize];
        end else if (in_upd && we_hi[s]) begin
          iv_q[s] <= ctr_i[s*SliceSize +: SliceSize];
        end
      end
      if (fatal) begin
        state_q <= ERROR;
      end else begin
        unique case (state_q)
          IDLE: if (pend_q != '0) state_q <= REQ;
          REQ: begin
            if (rdy_hi) begin
              state_q    <= WAIT;
              wait_cnt_q <= '0;
            end
          end
          WAIT: begin
            if (rdy_hi) wait_cnt_q <= wait_cnt_q + 2'd1;
            else        state_q    <= BUSY;
          end
          BUSY:    if (rdy_hi) state_q <= IDLE;
          ERROR:   state_q <= ERROR;
          default: state_q <= ERROR;
        endcase
      end
    end
  end

  assign iv_o        = iv_q;
  assign ctr_o       = iv_q;
  assign done_o      = done;
  assign blk_cnt_o   = blk_cnt_q;
  assign iv_wr_err_o = wr_err_q;
  assign alert_o     = (state_q == ERROR);

endmodule

// File: tb/tb_aes_ctr_iv_reg.sv
// Bench for aes_ctr_iv_reg: directed and randomized increments against
// a slice-array reference model of the counter register.
module tb_aes_ctr_iv_reg;

  localparam logic [2:0] HI = 3'b011;
  localparam logic [2:0] LO = 3'b100;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [7:0]   iv_we_i;
  logic [127:0] iv_wdata_i;
  logic         iv_wr_err_o;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         done_o;
  logic [31:0]  blk_cnt_o;
  logic [127:0] iv_o;
  logic [2:0]   incr_o;
  logic [2:0]   ready_i;
  logic [127:0] ctr_o;
  logic [127:0] ctr_i;
  logic [23:0]  ctr_we_i;
  logic         alert_i;
  logic         alert_o;

  always #5 clk_i = ~clk_i;

  aes_ctr_iv_reg dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iv_we_i(iv_we_i), .iv_wdata_i(iv_wdata_i),
    .iv_wr_err_o(iv_wr_err_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .done_o(done_o), .blk_cnt_o(blk_cnt_o), .iv_o(iv_o),
    .incr_o(incr_o), .ready_i(ready_i),
    .ctr_o(ctr_o), .ctr_i(ctr_i), .ctr_we_i(ctr_we_i),
    .alert_i(alert_i), .alert_o(alert_o)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] m_iv [8];
  int m_blk;
  int m_pend;

  function automatic logic [127:0] m_vec();
    logic [127:0] v;
    for (int s = 0; s < 8; s++) v[s*16 +: 16] = m_iv[s];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic m_reset();
    for (int s = 0; s < 8; s++) m_iv[s] = '0;
    m_blk  = 0;
    m_pend = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    m_reset();
    #1;
    chk("rst_iv", iv_o, 128'd0);
    chk("rst_blk", 128'(blk_cnt_o), 128'd0);
    chk("rst_incr", 128'(incr_o), 128'(LO));
    chk("rst_alert", 128'(alert_o), 128'd0);
    chk("rst_ready", 128'(req_ready_o), 128'd1);
  endtask

  task automatic sw_write(input logic [7:0] mask, input logic [127:0] d,
                          input bit ok);
    iv_we_i    = mask;
    iv_wdata_i = d;
    tick();
    iv_we_i = '0;
    if (ok) begin
      for (int s = 0; s < 8; s++) if (mask[s]) m_iv[s] = d[s*16 +: 16];
    end
    chk("wr_err", 128'(iv_wr_err_o), 128'(!ok));
    chk("wr_iv", iv_o, m_vec());
  endtask

  task automatic request();
    req_valid_i = 1'b1;
    #1;
    chk("req_ready", 128'(req_ready_o), 128'(m_pend < 4));
    tick();
    req_valid_i = 1'b0;
    m_pend++;
  endtask

  task automatic wait_incr();
    int n = 0;
    while (incr_o !== HI && n < 20) begin
      tick();
      n++;
    end
    chk("incr_hi", 128'(incr_o), 128'(HI));
  endtask

  task automatic to_busy();
    wait_incr();
    ready_i = HI;
    tick();
    ready_i = LO;
    tick();
  endtask

  task automatic incr_write(input logic [7:0] mask, input logic [127:0] d);
    for (int s = 0; s < 8; s++) ctr_we_i[3*s +: 3] = mask[s] ? HI : LO;
    ctr_i = d;
    tick();
    ctr_we_i = {8{LO}};
    for (int s = 0; s < 8; s++) if (mask[s]) m_iv[s] = d[s*16 +: 16];
    chk("upd_iv", iv_o, m_vec());
  endtask

  task automatic finish_busy();
    ready_i = HI;
    #1;
    chk("done_pulse", 128'(done_o), 128'd1);
    tick();
    ready_i = LO;
    m_blk++;
    m_pend--;
    #1;
    chk("done_clr", 128'(done_o), 128'd0);
    chk("blk_cnt", 128'(blk_cnt_o), 128'(m_blk));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [7:0]   mk;
    logic [127:0] d;
    int           acc;
    rst_i       = 1'b1;
    iv_we_i     = '0;
    iv_wdata_i  = '0;
    req_valid_i = 1'b0;
    ready_i     = LO;
    ctr_i       = '0;
    ctr_we_i    = {8{LO}};
    alert_i     = 1'b0;

    do_reset();

    sw_write(8'hFF, {8{16'hFFFF}}, 1'b1);
    request();
    chk("lat_n1", 128'(incr_o), 128'(LO));
    tick();
    chk("lat_n2", 128'(incr_o), 128'(HI));
    to_busy();
    incr_write(8'hFF, 128'd0);
    chk("zero_iv", iv_o, 128'd0);
    finish_busy();

    acc = 0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("q_ready", 128'(req_ready_o), 128'(m_pend < 4));
      if (m_pend < 4) begin
        m_pend++;
        acc++;
      end
      tick();
    end
    req_valid_i = 1'b0;
    chk("q_accepted", 128'(acc), 128'd4);
    for (int i = 0; i < 4; i++) begin
      to_busy();
      incr_write(8'($urandom_range(0, 255)), rnd128());
      finish_busy();
    end
    tick();
    tick();
    chk("q_drained", 128'(incr_o), 128'(LO));
    chk("ctr_o", ctr_o, m_vec());

    for (int i = 0; i < 4; i++) begin
      sw_write(8'($urandom_range(1, 255)), rnd128(), 1'b1);
      request();
      to_busy();
      incr_write(8'($urandom_range(0, 255)), rnd128());
      finish_busy();
    end

    sw_write(8'hFF, rnd128(), 1'b1);
    request();
    to_busy();
    incr_write(8'h03, rnd128());
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_reset();
    chk("mid_iv", iv_o, 128'd0);
    chk("mid_blk", 128'(blk_cnt_o), 128'd0);
    chk("mid_incr", 128'(incr_o), 128'(LO));
    chk("mid_alert", 128'(alert_o), 128'd0);
    chk("mid_err", 128'(iv_wr_err_o), 128'd0);
    chk("mid_done", 128'(done_o), 128'd0);
    chk("mid_ready", 128'(req_ready_o), 128'd1);

    d = rnd128();
    sw_write(8'hFF, d, 1'b1);
    request();
    to_busy();
    sw_write(8'h01, {8{16'h1234}}, 1'b0);
    tick();
    chk("err_pulse", 128'(iv_wr_err_o), 128'd0);
    chk("busy_iv", iv_o, d);

    ctr_we_i[11:9] = 3'b000;
    tick();
    ctr_we_i = {8{LO}};
    chk("bad_we_alert", 128'(alert_o), 128'd1);
    chk("bad_we_ready", 128'(req_ready_o), 128'd0);
    tick();
    tick();
    chk("alert_sticky", 128'(alert_o), 128'd1);

    do_reset();
    request();
    wait_incr();
    ready_i = HI;
    tick();
    tick();
    tick();
    chk("wait_2hi", 128'(alert_o), 128'd0);
    tick();
    ready_i = LO;
    chk("wait_3hi", 128'(alert_o), 128'd1);

    do_reset();
    alert_i = 1'b1;
    tick();
    alert_i = 1'b0;
    chk("alert_in", 128'(alert_o), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
